// File: rtl/sdram_stream_pkg.sv
// Constants and state encoding shared by the SDRAM stream-path FIFO controllers.
package sdram_stream_pkg;

  localparam int WORDS_PER_KBYTE = 512;
  localparam int FIFO_DEPTH      = 1024;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RECV = ST_RECV,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/byte_to_word_packer.sv
// Packs byte pairs (low byte first) into 16-bit FIFO words.
// Word and wrreq appear 1 clk after the second byte; wrreq is withheld while the FIFO is full.
module byte_to_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        fifo_full,
  output logic        word_issue,
  output logic [15:0] fifo_data,
  output logic        fifo_wrreq
);

  logic       phase;
  logic [7:0] low_byte;

  assign word_issue = byte_valid && phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      low_byte   <= 8'h00;
      fifo_data  <= 16'h0000;
      fifo_wrreq <= 1'b0;
    end else if (clr) begin
      phase      <= 1'b0;
      low_byte   <= 8'h00;
      fifo_wrreq <= 1'b0;
    end else begin
      fifo_wrreq <= word_issue && !fifo_full;
      if (byte_valid) begin
        if (!phase) begin
          low_byte <= byte_in;
          phase    <= 1'b1;
        end else begin
          fifo_data <= {byte_in, low_byte};
          phase     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_to_sdram_controller.sv
// Receives a 1-KByte byte frame, packs it into 16-bit words and writes them to the SDRAM-side FIFO.
// A frame is granted only when the FIFO can absorb it whole; a stalled frame aborts after TIMEOUT_CYCLES idle clocks.
module fifo_to_sdram_controller #(
  parameter int WORDS_PER_KBYTE = sdram_stream_pkg::WORDS_PER_KBYTE,
  parameter int FIFO_DEPTH      = sdram_stream_pkg::FIFO_DEPTH,
  parameter int USEDW_W         = 10,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  input  logic               prev_tx_rdy,
  output logic               this_rx_rdy,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic               fifo_full,
  output logic [15:0]        fifo_data,
  output logic               fifo_wrreq,
  output logic               kbyte_rdy,
  output logic               frame_active,
  input  logic               err_clr,
  output logic               overflow_err,
  output logic               timeout_err
);

  import sdram_stream_pkg::state_t;
  import sdram_stream_pkg::IDLE;
  import sdram_stream_pkg::RECV;
  import sdram_stream_pkg::DONE;

  localparam int WC_W = $clog2(WORDS_PER_KBYTE + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state, state_nxt;
  logic [WC_W-1:0] word_cnt;
  logic [TO_W-1:0] timeout_cnt;
  logic            start, abort, space, word_issue;

  // usedw reads 0 when the FIFO is completely full, hence the explicit full term.
  assign space        = !fifo_full &&
                        ({1'b0, fifo_usedw} <= (USEDW_W+1)'(FIFO_DEPTH - WORDS_PER_KBYTE));
  assign kbyte_rdy    = fifo_full || ({1'b0, fifo_usedw} >= (USEDW_W+1)'(WORDS_PER_KBYTE));
  assign this_rx_rdy  = (state == IDLE) && space;
  assign frame_active = (state == RECV);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (this_rx_rdy && prev_tx_rdy) begin
        state_nxt = RECV;
        start     = 1'b1;
      end
      RECV: begin
        if (word_issue && word_cnt == WC_W'(WORDS_PER_KBYTE - 1)) begin
          state_nxt = DONE;
        end else if (!byte_valid && timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = IDLE;
          abort     = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt     <= '0;
      timeout_cnt  <= '0;
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (start) begin
        word_cnt    <= '0;
        timeout_cnt <= '0;
      end else if (state == RECV) begin
        if (word_issue) word_cnt <= word_cnt + 1'b1;
        timeout_cnt <= byte_valid ? '0 : timeout_cnt + 1'b1;
      end
      // A new error event takes priority over a clear in the same clock.
      if (word_issue && fifo_full) overflow_err <= 1'b1;
      else if (err_clr)            overflow_err <= 1'b0;
      if (abort)        timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

  byte_to_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start || abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid && (state == RECV)),
    .fifo_full  (fifo_full),
    .word_issue (word_issue),
    .fifo_data  (fifo_data),
    .fifo_wrreq (fifo_wrreq)
  );

endmodule

// File: tb/tb_fifo_to_sdram_controller.sv
// Randomized bench for fifo_to_sdram_controller against a queue-based frame model.
module tb_fifo_to_sdram_controller;

  localparam int WPK     = 512;
  localparam int TIMEOUT = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        prev_tx_rdy;
  logic        this_rx_rdy;
  logic [9:0]  fifo_usedw;
  logic        fifo_full;
  logic [15:0] fifo_data;
  logic        fifo_wrreq;
  logic        kbyte_rdy;
  logic        frame_active;
  logic        err_clr;
  logic        overflow_err;
  logic        timeout_err;

  int          n_vec = 0;
  int          n_err = 0;
  int          wr_cnt = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_to_sdram_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .prev_tx_rdy  (prev_tx_rdy),
    .this_rx_rdy  (this_rx_rdy),
    .fifo_usedw   (fifo_usedw),
    .fifo_full    (fifo_full),
    .fifo_data    (fifo_data),
    .fifo_wrreq   (fifo_wrreq),
    .kbyte_rdy    (kbyte_rdy),
    .frame_active (frame_active),
    .err_clr      (err_clr),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write strobe must carry the next word the model expects.
  always @(negedge clk) begin
    if (rst_n && fifo_wrreq) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
      else                   chk("wr_data", {16'h0, fifo_data}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic start_frame();
    int n = 0;
    wr_cnt = 0;
    exp_q.delete();
    @(negedge clk);
    prev_tx_rdy = 1'b1;
    while (!frame_active && n < 8) begin
      @(negedge clk);
      n++;
    end
    prev_tx_rdy = 1'b0;  // dropping it mid-frame must not matter
    chk("grant", {31'h0, frame_active}, 32'd1);
  endtask

  // Sends n_bytes; words full_lo..full_hi see fifo_full, word clr_w sees err_clr alongside.
  task automatic run_frame(input int n_bytes, input bit pattern, input int full_lo,
                           input int full_hi, input int clr_w, output int exp_wr);
    logic [7:0] b, lo;
    int w;
    bit drop;
    exp_wr = 0;
    lo = 8'h00;
    for (int i = 0; i < n_bytes; i++) begin
      b = pattern ? 8'(i) : 8'($urandom);
      w = i / 2;
      drop = 1'b0;
      @(negedge clk);
      byte_in    = b;
      byte_valid = 1'b1;
      if (i % 2 == 1) begin
        drop      = (w >= full_lo) && (w <= full_hi);
        fifo_full = drop;
        err_clr   = (w == clr_w);
        if (!drop) begin
          exp_q.push_back({b, lo});
          exp_wr++;
        end
      end else begin
        lo = b;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      fifo_full  = 1'b0;
      err_clr    = 1'b0;
      if (i % 2 == 1 && w == clr_w)
        chk("ovf_set_beats_clr", {31'h0, overflow_err}, {31'h0, drop});
      if (!pattern && i < n_bytes - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    if (n_bytes == 2 * WPK) begin
      chk("done_frame_active", {31'h0, frame_active}, 32'd0);
      chk("done_rx_rdy", {31'h0, this_rx_rdy}, 32'd0);
      @(negedge clk);
      chk("idle_rx_rdy", {31'h0, this_rx_rdy}, 32'd1);
    end
  endtask

  task automatic end_frame(input int exp_wr);
    repeat (2) @(negedge clk);
    chk("wr_count", wr_cnt, exp_wr);
    chk("q_empty", exp_q.size(), 32'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_ovf", {31'h0, overflow_err}, 32'd0);
    chk("clr_tmo", {31'h0, timeout_err}, 32'd0);
  endtask

  initial begin
    int exp_wr, n;
    logic [9:0] u;
    logic f;
    rst_n = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; prev_tx_rdy = 1'b0;
    fifo_usedw = 10'd0; fifo_full = 1'b0; err_clr = 1'b0;
    #12;
    chk("rst_wrreq", {31'h0, fifo_wrreq}, 32'd0);
    chk("rst_data", {16'h0, fifo_data}, 32'd0);
    chk("rst_active", {31'h0, frame_active}, 32'd0);
    chk("rst_ovf", {31'h0, overflow_err}, 32'd0);
    chk("rst_tmo", {31'h0, timeout_err}, 32'd0);
    chk("rst_rx_rdy", {31'h0, this_rx_rdy}, 32'd1);
    chk("rst_kbyte", {31'h0, kbyte_rdy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Counting pattern at one byte every two clocks.
    start_frame();
    run_frame(2 * WPK, 1'b1, -1, -1, -1, exp_wr);
    end_frame(exp_wr);

    // Grant threshold and kbyte flag at the boundaries, then random fill levels.
    @(negedge clk);
    fifo_usedw = 10'd513; prev_tx_rdy = 1'b1;
    #1 chk("rdy_513", {31'h0, this_rx_rdy}, 32'd0);
    chk("kb_513", {31'h0, kbyte_rdy}, 32'd1);
    repeat (4) @(negedge clk);
    chk("no_grant_513", {31'h0, frame_active}, 32'd0);
    prev_tx_rdy = 1'b0;
    fifo_usedw = 10'd512;
    #1 chk("rdy_512", {31'h0, this_rx_rdy}, 32'd1);
    chk("kb_512", {31'h0, kbyte_rdy}, 32'd1);
    fifo_usedw = 10'd511;
    #1 chk("kb_511", {31'h0, kbyte_rdy}, 32'd0);
    fifo_full = 1'b1; fifo_usedw = 10'd0;
    #1 chk("rdy_full", {31'h0, this_rx_rdy}, 32'd0);
    chk("kb_full", {31'h0, kbyte_rdy}, 32'd1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      u = 10'($urandom);
      f = ($urandom_range(0, 3) == 0);
      fifo_usedw = u; fifo_full = f;
      #1;
      chk("rand_rdy", {31'h0, this_rx_rdy}, {31'h0, (!f && u <= 10'd512)});
      chk("rand_kb", {31'h0, kbyte_rdy}, {31'h0, (f || u >= 10'd512)});
    end
    @(negedge clk);
    fifo_usedw = 10'd0; fifo_full = 1'b0;

    // Three consecutive words hit a full FIFO.
    chk("ovf_pre", {31'h0, overflow_err}, 32'd0);
    start_frame();
    run_frame(2 * WPK, 1'b0, 100, 102, -1, exp_wr);
    end_frame(exp_wr);
    chk("ovf_words", exp_wr, WPK - 3);
    chk("ovf_flag", {31'h0, overflow_err}, 32'd1);
    pulse_clr();

    // Clear coincides with a fresh overflow event.
    start_frame();
    run_frame(2 * WPK, 1'b0, 20, 20, 20, exp_wr);
    end_frame(exp_wr);

    // Byte stream stalls after an odd byte count.
    start_frame();
    run_frame(301, 1'b0, -1, -1, -1, exp_wr);
    n = 0;
    while (frame_active && n < TIMEOUT + 100) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, TIMEOUT);
    chk("tmo_flag", {31'h0, timeout_err}, 32'd1);
    chk("tmo_idle", {31'h0, this_rx_rdy}, 32'd1);
    end_frame(exp_wr);
    chk("tmo_words", exp_wr, 150);
    pulse_clr();

    // Reset lands after word 200 with a low byte pending.
    start_frame();
    run_frame(401, 1'b0, 5, 5, -1, exp_wr);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wrreq", {31'h0, fifo_wrreq}, 32'd0);
    chk("mid_rst_data", {16'h0, fifo_data}, 32'd0);
    chk("mid_rst_active", {31'h0, frame_active}, 32'd0);
    chk("mid_rst_ovf", {31'h0, overflow_err}, 32'd0);
    chk("mid_rst_words", wr_cnt, exp_wr);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh frame must start pairing from a low byte.
    start_frame();
    run_frame(2 * WPK, 1'b0, -1, -1, -1, exp_wr);
    end_frame(exp_wr);
    chk("post_rst_words", exp_wr, WPK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
